// File: rtl/tranif_mbe_encoder_if.sv
// Purpose: bus bundle between the multiplier-word producer and the radix-4
//          modified-Booth encoder stage.
// Signals:
//   valid_in  - producer -> encoder, y is valid this cycle
//   y         - producer -> encoder, multiplier word (WIDTH bits)
//   valid_out - encoder  -> consumer, registered valid_in
//   single    - encoder  -> consumer, per-digit "select 1x multiplicand" (N bits)
//   double    - encoder  -> consumer, per-digit "select 2x multiplicand" (N bits)
//   neg       - encoder  -> consumer, per-digit "negate selected multiplicand" (N bits)
//   zero      - encoder  -> consumer, per-digit "digit value is 0" (N bits)
// Modports: master = producer/consumer side, slave = encoder side.
interface tranif_mbe_encoder_if #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
);
  // Unsigned words need one extra digit to absorb the zero-extension.
  localparam int unsigned N = SIGNED ? (WIDTH / 2) : (WIDTH / 2 + 1);

  logic             valid_in;
  logic [WIDTH-1:0] y;
  logic             valid_out;
  logic [N-1:0]     single;
  logic [N-1:0]     double;
  logic [N-1:0]     neg;
  logic [N-1:0]     zero;

  modport master (
    output valid_in, y,
    input  valid_out, single, double, neg, zero
  );

  modport slave (
    input  valid_in, y,
    output valid_out, single, double, neg, zero
  );
endinterface

// File: rtl/tranif_mbe_encoder.sv
// Purpose: registered radix-4 modified-Booth encoder array. Slices the
//          multiplier word into overlapping 3-bit groups and emits, one clock
//          later, the per-digit single/double/neg/zero select lines for the
//          partial-product mux rows.
// Parameters:
//   WIDTH  - multiplier width, even and >= 4
//   SIGNED - 1: two's-complement y, WIDTH/2 digits
//            0: unsigned y (zero-extended by 2 bits), WIDTH/2+1 digits
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - slave side of tranif_mbe_encoder_if (valid_in/y in,
//             valid_out/single/double/neg/zero out)
module tranif_mbe_encoder #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tranif_mbe_encoder_if.slave   bus
);

  localparam int unsigned N  = SIGNED ? (WIDTH / 2) : (WIDTH / 2 + 1);
  // Digit N-1 reads e[2N:2N-2], so exactly 2N+1 extended bits are needed.
  localparam int unsigned EW = 2 * N + 1;

  logic [EW-1:0] w_e;
  logic [N-1:0]  w_single;
  logic [N-1:0]  w_double;
  logic [N-1:0]  w_neg;
  logic [N-1:0]  w_zero;

  logic          r_valid;
  logic [N-1:0]  r_single;
  logic [N-1:0]  r_double;
  logic [N-1:0]  r_neg;
  logic [N-1:0]  r_zero;

  // Extended operand {ext, y, y[-1]=0}; a signed word's top digit already
  // sees the sign bit as x2, so no sign replication bits are ever read.
  if (SIGNED) begin : g_ext_signed
    assign w_e = {bus.y, 1'b0};
  end else begin : g_ext_unsigned
    assign w_e = {2'b00, bus.y, 1'b0};
  end

  // Per-digit mbe_1x cell; triple 111 intentionally gives neg=1, magnitude 0.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_digit
    logic w_x2;
    logic w_x1;
    logic w_x0;
    assign w_x2          = w_e[2*gi+2];
    assign w_x1          = w_e[2*gi+1];
    assign w_x0          = w_e[2*gi];
    assign w_single[gi]  = w_x1 ^ w_x0;
    assign w_double[gi]  = (w_x2 ^ w_x0) & ~w_single[gi];
    assign w_neg[gi]     = w_x2;
    assign w_zero[gi]    = ~w_single[gi] & ~w_double[gi];
  end

  // Single pipeline stage; digit lines update every cycle regardless of valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_single <= '0;
      r_double <= '0;
      r_neg    <= '0;
      r_zero   <= '1;
    end else begin
      r_valid  <= bus.valid_in;
      r_single <= w_single;
      r_double <= w_double;
      r_neg    <= w_neg;
      r_zero   <= w_zero;
    end
  end

  assign bus.valid_out = r_valid;
  assign bus.single    = r_single;
  assign bus.double    = r_double;
  assign bus.neg       = r_neg;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_tranif_mbe_encoder.sv
// Bench for tranif_mbe_encoder: three instances (W4 signed, W8 signed,
// W8 unsigned) share clock, reset and valid; expected results are queued
// when stimulus is driven and popped when valid_out rises.
module tb_tranif_mbe_encoder;

  typedef struct {
    logic       chk;   // compare exact select lines as well as the sum
    logic [7:0] y;
    int         val;   // value the digit sum must reconstruct
    logic [4:0] s, d, n, z;
  } sb_t;

  typedef struct {
    logic [3:0] y;
    logic [4:0] s, d, n, z;
  } vec4_t;

  typedef struct {
    logic [7:0] y;
    logic [4:0] ss, ds, ns, zs;   // SIGNED=1 expectations
    logic [4:0] su, du, nu, zu;   // SIGNED=0 expectations
  } vec8_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic exp_vld = 1'b0;
  logic mon_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  sb_t  q4[$];
  sb_t  q8s[$];
  sb_t  q8u[$];

  tranif_mbe_encoder_if #(.WIDTH(4), .SIGNED(1'b1)) if4 ();
  tranif_mbe_encoder_if #(.WIDTH(8), .SIGNED(1'b1)) if8s ();
  tranif_mbe_encoder_if #(.WIDTH(8), .SIGNED(1'b0)) if8u ();

  tranif_mbe_encoder #(.WIDTH(4), .SIGNED(1'b1)) u4 (
    .clk(clk), .reset_n(reset_n), .bus(if4));
  tranif_mbe_encoder #(.WIDTH(8), .SIGNED(1'b1)) u8s (
    .clk(clk), .reset_n(reset_n), .bus(if8s));
  tranif_mbe_encoder #(.WIDTH(8), .SIGNED(1'b0)) u8u (
    .clk(clk), .reset_n(reset_n), .bus(if8u));

  always #5 clk = ~clk;

  always @(posedge clk) exp_vld <= reset_n ? if8s.valid_in : 1'b0;

  task automatic cmp(string nm, logic [4:0] act, logic [4:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic cmp_int(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int dec(int nd, logic [4:0] s, logic [4:0] d, logic [4:0] n);
    int sum = 0;
    for (int i = 0; i < nd; i++) begin
      int m;
      m = int'(s[i]) + 2 * int'(d[i]);
      if (n[i]) m = -m;
      sum += m * (1 << (2 * i));
    end
    return sum;
  endfunction

  function automatic sb_t mk(int w, bit sgn, bit chk, logic [7:0] y,
                             logic [4:0] s, logic [4:0] d, logic [4:0] n, logic [4:0] z);
    sb_t e;
    logic [3:0] y4;
    y4 = y[3:0];
    e.chk = chk; e.y = y; e.s = s; e.d = d; e.n = n; e.z = z;
    if (w == 4) e.val = sgn ? int'($signed(y4)) : int'(y4);
    else        e.val = sgn ? int'($signed(y))  : int'(y);
    return e;
  endfunction

  task automatic check_out(string nm, int nd, sb_t e,
                           logic [4:0] s, logic [4:0] d, logic [4:0] n, logic [4:0] z);
    logic [4:0] mask;
    mask = 5'((1 << nd) - 1);
    if (e.chk) begin
      cmp({nm, "_single"}, s, e.s);
      cmp({nm, "_double"}, d, e.d);
      cmp({nm, "_neg"},    n, e.n);
      cmp({nm, "_zero"},   z, e.z);
    end
    cmp_int({nm, "_digit_sum"}, dec(nd, s, d, n), e.val);
    cmp({nm, "_single_and_double"}, s & d, 5'd0);
    cmp({nm, "_zero_consistent"}, z, ~(s | d) & mask);
  endtask

  task automatic chk_state(string nm, logic v, logic [4:0] s, logic [4:0] d,
                           logic [4:0] n, logic [4:0] z, logic ev, logic [4:0] es,
                           logic [4:0] ed, logic [4:0] en, logic [4:0] ez);
    cmp({nm, "_valid_out"}, 5'(v), 5'(ev));
    cmp({nm, "_single"}, s, es);
    cmp({nm, "_double"}, d, ed);
    cmp({nm, "_neg"},    n, en);
    cmp({nm, "_zero"},   z, ez);
  endtask

  task automatic check_reset(string tag);
    chk_state({tag, "_w4"}, if4.valid_out, 5'(if4.single), 5'(if4.double),
              5'(if4.neg), 5'(if4.zero), 1'b0, 5'd0, 5'd0, 5'd0, 5'b00011);
    chk_state({tag, "_w8s"}, if8s.valid_out, 5'(if8s.single), 5'(if8s.double),
              5'(if8s.neg), 5'(if8s.zero), 1'b0, 5'd0, 5'd0, 5'd0, 5'b01111);
    chk_state({tag, "_w8u"}, if8u.valid_out, if8u.single, if8u.double,
              if8u.neg, if8u.zero, 1'b0, 5'd0, 5'd0, 5'd0, 5'b11111);
  endtask

  // Drive one cycle starting at a negedge; returns at the next negedge.
  task automatic apply(bit v, bit rst, sb_t e4, sb_t e8s, sb_t e8u);
    if4.valid_in  = v;
    if8s.valid_in = v;
    if8u.valid_in = v;
    if4.y  = e4.y[3:0];
    if8s.y = e8s.y;
    if8u.y = e8u.y;
    reset_n = ~rst;
    if (v && !rst) begin
      q4.push_back(e4);
      q8s.push_back(e8s);
      q8u.push_back(e8u);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_rand(bit v, bit rst, logic [7:0] y8);
    logic [7:0] y4;
    y4 = 8'($urandom_range(0, 15));
    apply(v, rst, mk(4, 1'b1, 1'b0, y4, 5'd0, 5'd0, 5'd0, 5'd0),
          mk(8, 1'b1, 1'b0, y8, 5'd0, 5'd0, 5'd0, 5'd0),
          mk(8, 1'b0, 1'b0, y8, 5'd0, 5'd0, 5'd0, 5'd0));
  endtask

  // Scoreboard monitor: pops one expectation per instance whenever valid_out is high.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      cmp("valid_out_follow", 5'(if8s.valid_out), 5'(exp_vld));
      if (if4.valid_out) begin
        if (q4.size() == 0) cmp("w4_unexpected_output", 5'd1, 5'd0);
        else begin
          e = q4.pop_front();
          check_out("w4", 2, e, 5'(if4.single), 5'(if4.double), 5'(if4.neg), 5'(if4.zero));
        end
      end
      if (if8s.valid_out) begin
        if (q8s.size() == 0) cmp("w8s_unexpected_output", 5'd1, 5'd0);
        else begin
          e = q8s.pop_front();
          check_out("w8s", 4, e, 5'(if8s.single), 5'(if8s.double), 5'(if8s.neg), 5'(if8s.zero));
        end
      end
      if (if8u.valid_out) begin
        if (q8u.size() == 0) cmp("w8u_unexpected_output", 5'd1, 5'd0);
        else begin
          e = q8u.pop_front();
          check_out("w8u", 5, e, if8u.single, if8u.double, if8u.neg, if8u.zero);
        end
      end
    end
  end

  initial begin
    vec4_t t4[8];
    vec8_t t8[4];

    // y = {x2,x1,x0,0}: digit 1 walks every triple, digit 0 sees {x0,0,0}.
    t4[0] = '{4'h0, 5'b00, 5'b00, 5'b00, 5'b11};
    t4[1] = '{4'h2, 5'b10, 5'b01, 5'b01, 5'b00};
    t4[2] = '{4'h4, 5'b10, 5'b00, 5'b00, 5'b01};
    t4[3] = '{4'h6, 5'b00, 5'b11, 5'b01, 5'b00};
    t4[4] = '{4'h8, 5'b00, 5'b10, 5'b10, 5'b01};
    t4[5] = '{4'hA, 5'b10, 5'b01, 5'b11, 5'b00};
    t4[6] = '{4'hC, 5'b10, 5'b00, 5'b10, 5'b01};
    t4[7] = '{4'hE, 5'b00, 5'b01, 5'b11, 5'b10};

    t8[0] = '{8'h00, 5'b00000, 5'b00000, 5'b00000, 5'b01111,
                     5'b00000, 5'b00000, 5'b00000, 5'b11111};
    t8[1] = '{8'hFF, 5'b00001, 5'b00000, 5'b01111, 5'b01110,
                     5'b10001, 5'b00000, 5'b01111, 5'b01110};
    t8[2] = '{8'h5A, 5'b01010, 5'b00101, 5'b00011, 5'b00000,
                     5'b01010, 5'b00101, 5'b00011, 5'b10000};
    t8[3] = '{8'h80, 5'b00000, 5'b01000, 5'b01000, 5'b00111,
                     5'b10000, 5'b01000, 5'b01000, 5'b00111};

    if4.valid_in = 1'b0;  if4.y  = '0;
    if8s.valid_in = 1'b0; if8s.y = '0;
    if8u.valid_in = 1'b0; if8u.y = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [7:0] y4w;
      logic [7:0] y8;
      y4w = 8'(t4[i].y);
      y8  = 8'($urandom);
      apply(1'b1, 1'b0, mk(4, 1'b1, 1'b1, y4w, t4[i].s, t4[i].d, t4[i].n, t4[i].z),
            mk(8, 1'b1, 1'b0, y8, 5'd0, 5'd0, 5'd0, 5'd0),
            mk(8, 1'b0, 1'b0, y8, 5'd0, 5'd0, 5'd0, 5'd0));
    end

    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, mk(4, 1'b1, 1'b0, t8[i].y & 8'h0F, 5'd0, 5'd0, 5'd0, 5'd0),
            mk(8, 1'b1, 1'b1, t8[i].y, t8[i].ss, t8[i].ds, t8[i].ns, t8[i].zs),
            mk(8, 1'b0, 1'b1, t8[i].y, t8[i].su, t8[i].du, t8[i].nu, t8[i].zu));
    end

    // valid_in low: digit lines still follow y, valid_out stays low.
    apply_rand(1'b1, 1'b0, 8'h33);
    apply(1'b0, 1'b0, mk(4, 1'b1, 1'b0, 8'h0E, 5'd0, 5'd0, 5'd0, 5'd0),
          mk(8, 1'b1, 1'b0, 8'hFF, 5'd0, 5'd0, 5'd0, 5'd0),
          mk(8, 1'b0, 1'b0, 8'hFF, 5'd0, 5'd0, 5'd0, 5'd0));
    chk_state("nohold_w4", if4.valid_out, 5'(if4.single), 5'(if4.double),
              5'(if4.neg), 5'(if4.zero), 1'b0, 5'b00, 5'b01, 5'b11, 5'b10);
    chk_state("nohold_w8s", if8s.valid_out, 5'(if8s.single), 5'(if8s.double),
              5'(if8s.neg), 5'(if8s.zero), 1'b0, 5'b00001, 5'b00000, 5'b01111, 5'b01110);
    chk_state("nohold_w8u", if8u.valid_out, if8u.single, if8u.double,
              if8u.neg, if8u.zero, 1'b0, 5'b10001, 5'b00000, 5'b01111, 5'b01110);

    // Reset mid-stream wins over valid_in, then the next word encodes normally.
    apply(1'b1, 1'b0, mk(4, 1'b1, 1'b0, 8'h0A, 5'd0, 5'd0, 5'd0, 5'd0),
          mk(8, 1'b1, 1'b1, 8'h5A, t8[2].ss, t8[2].ds, t8[2].ns, t8[2].zs),
          mk(8, 1'b0, 1'b1, 8'h5A, t8[2].su, t8[2].du, t8[2].nu, t8[2].zu));
    apply_rand(1'b1, 1'b1, 8'h5A);
    check_reset("midreset");
    apply_rand(1'b1, 1'b0, 8'hC3);

    for (int i = 0; i < 1000; i++) apply_rand(1'b1, 1'b0, 8'($urandom));

    apply_rand(1'b0, 1'b0, 8'h00);
    cmp_int("w4_queue_drained",  q4.size(),  0);
    cmp_int("w8s_queue_drained", q8s.size(), 0);
    cmp_int("w8u_queue_drained", q8u.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
